// File: rtl/svm_pkg.sv
// svm_pkg: shared definitions for the sequential SVM recall engine.
//   - state_t : engine FSM states (IDLE, DOT, SCALE, BIAS, DONE)
//   - *_D     : default configuration values used by svm_recall_seq
//   - WORDS, ADDR_W, DOT_W : register-file size, config address width and
//                            dot-product width for the default configuration
//   - sm_to_tc : sign-magnitude to two's-complement conversion
package svm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOT   = 3'd1,
        SCALE = 3'd2,
        BIAS  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DIM_D    = 2;
    localparam int NUM_SV_D = 2;
    localparam int FEAT_W_D = 7;
    localparam int SV_W_D   = 8;
    localparam int ACC_W_D  = 24;

    localparam int WORDS  = NUM_SV_D * (DIM_D + 1);
    localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int DOT_W  = FEAT_W_D + SV_W_D + $clog2(DIM_D);

    // Low width-1 bits are the magnitude, bit width-1 the sign.
    // Negative zero naturally maps to 0.
    function automatic logic signed [31:0] sm_to_tc(input logic [31:0] value,
                                                    input int          width);
        logic [31:0] mag;
        mag = value & ((32'd1 << (width - 1)) - 32'd1);
        return value[width-1] ? -$signed(mag) : $signed(mag);
    endfunction

endpackage

// File: rtl/svm_sm_mac.sv
// svm_sm_mac: single signed multiply-accumulate.
//   u   : unsigned operand (UW bits)
//   sm  : sign-magnitude operand (SW bits, MSB = sign)
//   acc : two's-complement addend (PW bits)
//   sum : acc + u * sm, two's complement (PW bits)
// PW must be at least UW+SW so the product never wraps.
module svm_sm_mac
    import svm_pkg::*;
#(
    parameter int UW = 16,
    parameter int SW = 8,
    parameter int PW = 25
) (
    input  logic [UW-1:0]        u,
    input  logic [SW-1:0]        sm,
    input  logic signed [PW-1:0] acc,
    output logic signed [PW-1:0] sum
);

    logic signed [PW-1:0] ue;
    logic signed [PW-1:0] se;

    always_comb begin
        ue  = PW'($signed({1'b0, u}));
        se  = PW'(sm_to_tc(32'(sm), SW));
        sum = acc + ue * se;
    end

endmodule

// File: rtl/svm_recall_seq.sv
// svm_recall_seq: sequential linear-kernel SVM recall engine.
//   decision = bias + sum_j alpha_j * (sum_i sv_j,i * x_i), one MAC per cycle.
// Ports:
//   Bus2IP_Clk, Bus2IP_Resetn : clock, synchronous active-low reset
//   cfg_we/cfg_addr/cfg_wdata : register-file write (sv_j,i at j*(DIM+1)+i,
//                               alpha_j at j*(DIM+1)+DIM), only when not computing
//   bias                      : two's-complement bias, sampled at accept
//   in_valid/in_ready/feature : feature-vector handshake, element 0 at MSBs
//   out_valid/out_ready       : result handshake
//   result/decision/sat       : class bit, saturated decision, saturation flag
//   busy                      : engine not in IDLE
module svm_recall_seq
    import svm_pkg::*;
#(
    parameter int DIM    = DIM_D,
    parameter int NUM_SV = NUM_SV_D,
    parameter int FEAT_W = FEAT_W_D,
    parameter int SV_W   = SV_W_D,
    parameter int ACC_W  = ACC_W_D,
    localparam int NWORDS = NUM_SV * (DIM + 1),
    localparam int AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                  Bus2IP_Clk,
    input  logic                  Bus2IP_Resetn,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [SV_W-1:0]       cfg_wdata,
    input  logic [ACC_W-1:0]      bias,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIM*FEAT_W-1:0] feature,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  result,
    output logic [ACC_W-1:0]      decision,
    output logic                  sat,
    output logic                  busy
);

    localparam int DW   = FEAT_W + SV_W + $clog2(DIM);
    localparam int PW   = DW + SV_W + 1;
    localparam int IW   = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int JW   = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;
    localparam int WIDE = 64;

    localparam logic signed [WIDE-1:0] ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam logic signed [WIDE-1:0] ACC_MIN = -(64'sd1 <<< (ACC_W - 1));

    function automatic logic signed [ACC_W-1:0] clamp_acc(input logic signed [WIDE-1:0] v);
        if (v > ACC_MAX) return ACC_W'(ACC_MAX);
        if (v < ACC_MIN) return ACC_W'(ACC_MIN);
        return ACC_W'(v);
    endfunction

    function automatic logic clamp_hit(input logic signed [WIDE-1:0] v);
        return (v > ACC_MAX) || (v < ACC_MIN);
    endfunction

    state_t state_q, state_d;

    logic [SV_W-1:0]         rf [NWORDS];
    logic [DIM*FEAT_W-1:0]   feat_q;
    logic signed [ACC_W-1:0] bias_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [DW-1:0]    dot_q;
    logic                    sat_w;
    logic [IW-1:0]           i_q;
    logic [JW-1:0]           j_q;

    logic                    last_i, last_j, cfg_ok;
    logic [AW-1:0]           rd_addr;
    logic [SV_W-1:0]         rd_word;
    logic [FEAT_W-1:0]       x_i;
    logic [DW-1:0]           dot_mag;
    logic [DW-1:0]           mac_u;
    logic [SV_W-1:0]         mac_sm;
    logic signed [PW-1:0]    mac_acc, mac_sum;
    logic signed [WIDE-1:0]  term_w, scale_sum, bias_sum;
    logic signed [ACC_W-1:0] scaled, final_acc;

    assign last_i = (i_q == IW'(DIM - 1));
    assign last_j = (j_q == JW'(NUM_SV - 1));
    // Config is frozen only while a vector is being computed.
    assign cfg_ok = cfg_we && (state_q == IDLE || state_q == DONE)
                    && (int'(cfg_addr) < NWORDS);

    // SCALE reads alpha_j (slot DIM of vector j); DOT reads sv_j,i.
    always_comb begin
        rd_addr = AW'(int'(j_q) * (DIM + 1) + ((state_q == SCALE) ? DIM : int'(i_q)));
        rd_word = rf[rd_addr];
        x_i     = feat_q[(DIM - 1 - int'(i_q)) * FEAT_W +: FEAT_W];
        dot_mag = dot_q[DW-1] ? DW'(-dot_q) : DW'(dot_q);
    end

    // The one MAC is shared: DOT feeds x_i * sv_j,i + dot; SCALE feeds
    // |dot| * alpha_j with the dot sign folded into alpha's sign bit.
    always_comb begin
        mac_u   = DW'(x_i);
        mac_sm  = rd_word;
        mac_acc = PW'(dot_q);
        if (state_q == SCALE) begin
            mac_u   = dot_mag;
            mac_sm  = {rd_word[SV_W-1] ^ dot_q[DW-1], rd_word[SV_W-2:0]};
            mac_acc = '0;
        end
    end

    svm_sm_mac #(.UW(DW), .SW(SV_W), .PW(PW)) u_mac (
        .u   (mac_u),
        .sm  (mac_sm),
        .acc (mac_acc),
        .sum (mac_sum)
    );

    always_comb begin
        term_w    = WIDE'(mac_sum);
        scaled    = clamp_acc(term_w);
        scale_sum = WIDE'(acc_q) + WIDE'(scaled);
        bias_sum  = WIDE'(acc_q) + WIDE'(bias_q);
        final_acc = clamp_acc(bias_sum);
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = DOT;
            end
            DOT:   if (last_i) state_d = SCALE;
            SCALE: state_d = last_j ? BIAS : DOT;
            BIAS:  state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            for (int k = 0; k < NWORDS; k++) rf[k] <= '0;
            feat_q   <= '0;
            bias_q   <= '0;
            acc_q    <= '0;
            dot_q    <= '0;
            sat_w    <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            decision <= '0;
            result   <= 1'b0;
            sat      <= 1'b0;
        end else begin
            if (cfg_ok) rf[cfg_addr] <= cfg_wdata;
            unique case (state_q)
                IDLE: if (in_valid) begin
                    feat_q <= feature;
                    bias_q <= bias;
                    acc_q  <= '0;
                    dot_q  <= '0;
                    sat_w  <= 1'b0;
                    i_q    <= '0;
                    j_q    <= '0;
                end
                DOT: begin
                    dot_q <= DW'(mac_sum);
                    if (!last_i) i_q <= i_q + IW'(1);
                end
                SCALE: begin
                    acc_q <= clamp_acc(scale_sum);
                    sat_w <= sat_w | clamp_hit(term_w) | clamp_hit(scale_sum);
                    dot_q <= '0;
                    if (!last_j) begin
                        j_q <= j_q + JW'(1);
                        i_q <= '0;
                    end
                end
                BIAS: begin
                    decision <= final_acc;
                    result   <= ~final_acc[ACC_W-1];
                    sat      <= sat_w | clamp_hit(bias_sum);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_recall_seq.sv
module tb_svm_recall_seq;
    import svm_pkg::*;

    localparam int AW = ADDR_W;

    logic               clk = 1'b0;
    logic               rstn;
    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [7:0]         cfg_wdata;
    logic [23:0]        bias;
    logic               in_valid;
    logic               in_ready;
    logic [13:0]        feature;
    logic               out_valid;
    logic               out_ready;
    logic               result;
    logic [23:0]        decision;
    logic               sat;
    logic               busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] dec;
        logic        res;
        logic        sat;
    } exp_t;
    exp_t q[$];

    logic [7:0] sh [WORDS];

    always #5 clk = ~clk;

    svm_recall_seq dut (
        .Bus2IP_Clk    (clk),
        .Bus2IP_Resetn (rstn),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .bias          (bias),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .feature       (feature),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .decision      (decision),
        .sat           (sat),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint smv(input logic [7:0] w);
        longint m;
        m = longint'(w[6:0]);
        return w[7] ? -m : m;
    endfunction

    function automatic bit hit(input longint v);
        return (v > 64'sd8388607) || (v < -64'sd8388608);
    endfunction

    function automatic longint clampv(input longint v);
        if (v > 64'sd8388607)  return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    function automatic logic [23:0] model(input logic [6:0] x0, input logic [6:0] x1,
                                          input logic [23:0] b, output logic s);
        longint acc, dot, term;
        s   = 1'b0;
        acc = 0;
        for (int j = 0; j < 2; j++) begin
            dot  = longint'(x0) * smv(sh[j*3]) + longint'(x1) * smv(sh[j*3+1]);
            term = smv(sh[j*3+2]) * dot;
            if (hit(term)) s = 1'b1;
            term = clampv(term);
            acc  = acc + term;
            if (hit(acc)) s = 1'b1;
            acc  = clampv(acc);
        end
        acc = acc + longint'($signed(b));
        if (hit(acc)) s = 1'b1;
        acc = clampv(acc);
        return acc[23:0];
    endfunction

    task automatic wr(input int addr, input logic [7:0] data);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
        if (addr < WORDS) sh[addr] = data;
    endtask

    task automatic expect_out(input logic [23:0] d, input logic r, input logic s);
        exp_t e;
        e.dec = d;
        e.res = r;
        e.sat = s;
        q.push_back(e);
    endtask

    // Returns at the falling edge after the accepting edge.
    task automatic start(input logic [6:0] x0, input logic [6:0] x1, input logic [23:0] b);
        @(negedge clk);
        feature  = {x0, x1};
        bias     = b;
        in_valid = 1'b1;
        check("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int pre, input int hold);
        int   cnt;
        exp_t e;
        cnt = pre;
        while (!out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("latency", 32'(cnt), 32'd7);
        if (q.size() == 0) begin
            check("queue_empty", 32'(q.size()), 32'd1);
            return;
        end
        e = q.pop_front();
        check("decision", 32'(decision), 32'(e.dec));
        check("result", 32'(result), 32'(e.res));
        check("sat", 32'(sat), 32'(e.sat));
        check("done_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_decision", 32'(decision), 32'(e.dec));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [23:0] d;
        logic        s;
        logic [6:0]  rx0, rx1;
        logic [23:0] rb;
        int          seen;

        rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; bias = '0;
        in_valid = 1'b0; feature = '0; out_ready = 1'b0;
        for (int k = 0; k < WORDS; k++) sh[k] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_decision", 32'(decision), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;

        // Positive case, plus 5 cycles of out_ready low
        wr(0, 8'h03); wr(1, 8'h82); wr(2, 8'h01); wr(3, 8'h00); wr(4, 8'h00); wr(5, 8'h00);
        expect_out(24'd20, 1'b1, 1'b0);
        start(7'd10, 7'd5, 24'h0);
        check("dot_busy", 32'(busy), 32'd1);
        collect(0, 5);

        // Negative case
        wr(0, 8'h83); wr(1, 8'h02);
        expect_out(24'hFFFFEC, 1'b0, 1'b0);
        start(7'd10, 7'd5, 24'h0);
        collect(0, 0);

        // Exact zero with negative-zero words
        wr(0, 8'h01); wr(1, 8'h81); wr(3, 8'h80); wr(4, 8'h80); wr(5, 8'h80);
        expect_out(24'h000000, 1'b1, 1'b0);
        start(7'd5, 7'd5, 24'h0);
        collect(0, 0);

        // Positive saturation through the bias add
        wr(0, 8'h7F); wr(1, 8'h00); wr(2, 8'h7F);
        expect_out(24'h7FFFFF, 1'b1, 1'b1);
        start(7'd127, 7'd0, 24'h7FFFFF);
        collect(0, 0);

        // Negative saturation: -4096766 + -2^23 clamps to -2^23
        wr(0, 8'hFF); wr(1, 8'hFF);
        expect_out(24'h800000, 1'b0, 1'b1);
        start(7'd127, 7'd127, 24'h800000);
        collect(0, 0);

        // Config write while in DOT must be ignored
        wr(0, 8'h03); wr(1, 8'h82); wr(2, 8'h01); wr(3, 8'h00); wr(4, 8'h00); wr(5, 8'h00);
        expect_out(24'd20, 1'b1, 1'b0);
        start(7'd10, 7'd5, 24'h0);
        cfg_we = 1'b1; cfg_addr = AW'(1); cfg_wdata = 8'h7F;
        @(negedge clk);
        cfg_we = 1'b0;
        collect(1, 0);
        expect_out(24'd20, 1'b1, 1'b0);
        start(7'd10, 7'd5, 24'h0);
        collect(0, 0);

        // Write and accept on the same edge: new sv0,0 = 5 -> 50 - 10
        expect_out(24'd40, 1'b1, 1'b0);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = AW'(0); cfg_wdata = 8'h05;
        feature = {7'd10, 7'd5}; bias = 24'h0; in_valid = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        sh[0] = 8'h05;
        collect(0, 0);

        // Randomised configurations against the bench model
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < WORDS; k++) wr(k, 8'($urandom_range(0, 255)));
            rx0 = 7'($urandom_range(0, 127));
            rx1 = 7'($urandom_range(0, 127));
            rb  = 24'($urandom);
            d = model(rx0, rx1, rb, s);
            expect_out(d, ~d[23], s);
            start(rx0, rx1, rb);
            collect(0, 0);
        end

        // Reset while in SCALE aborts with no output and clears the register file
        start(7'd10, 7'd5, 24'h0);
        @(negedge clk);
        @(negedge clk);
        check("abort_in_scale", 32'(busy), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < WORDS; k++) sh[k] = 8'h00;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_output", 32'(seen), 32'd0);

        // Out-of-range address is ignored; cleared file gives decision = bias
        wr(WORDS + 1, 8'h7F);
        expect_out(24'd5, 1'b1, 1'b0);
        start(7'd3, 7'd4, 24'd5);
        collect(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
